// File: rtl/udma_hyper_tx_prefetch.sv
// TX prefetch buffer between the uDMA TX channel and the HyperBus TX stream.
// Outstanding requests are tracked as credits so returned data always has a slot.
module udma_hyper_tx_prefetch #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BUFFER_DEPTH    = 16,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned LVL_W           = $clog2(BUFFER_DEPTH + 1),
  parameter int unsigned OUT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  sys_clk_i,
  input  logic                  rstn_i,
  input  logic                  clr_i,
  input  logic [LVL_W-1:0]      cfg_low_i,
  output logic                  req_o,
  input  logic                  gnt_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [LVL_W-1:0]      level_o,
  output logic [OUT_W-1:0]      outstanding_o,
  output logic                  err_o
);

  localparam int unsigned PTR_W = $clog2(BUFFER_DEPTH);
  localparam int unsigned RES_W = LVL_W + 1;
  localparam logic [RES_W-1:0] DEPTH_RES = RES_W'(BUFFER_DEPTH);
  localparam logic [OUT_W-1:0] MAX_OUT   = OUT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUFFER_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FILL, DROP} state_t;

  state_t                state, state_next;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [LVL_W-1:0]      level, level_next;
  logic [OUT_W-1:0]      outstanding, outstanding_next;
  logic                  err, err_next;
  logic                  grant, ret, push, pop;
  logic [RES_W-1:0]      reserved, reserved_next;
  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];

  assign ready_o       = 1'b1;
  assign valid_o       = (level != '0);
  assign data_o        = valid_o ? mem[rd_ptr] : '0;
  assign level_o       = level;
  assign outstanding_o = outstanding;
  assign err_o         = err;

  always_comb begin
    grant            = 1'b0;
    ret              = 1'b0;
    push             = 1'b0;
    pop              = 1'b0;
    req_o            = 1'b0;
    reserved         = '0;
    reserved_next    = '0;
    outstanding_next = outstanding;
    level_next       = level;
    err_next         = err;
    state_next       = state;

    reserved = RES_W'(level) + RES_W'(outstanding);
    req_o    = (state == FILL) && (outstanding < MAX_OUT) && (reserved < DEPTH_RES);
    grant    = req_o & gnt_i;
    // A beat only consumes a credit if one exists; otherwise it is a protocol error.
    ret      = valid_i & (outstanding != '0);
    push     = ret & ready_o & (state != DROP) & ~clr_i;
    pop      = valid_o & ready_i & ~clr_i;

    outstanding_next = outstanding + OUT_W'(grant) - OUT_W'(ret);
    level_next       = clr_i ? '0 : (level + LVL_W'(push) - LVL_W'(pop));
    reserved_next    = RES_W'(level_next) + RES_W'(outstanding_next);
    err_next         = clr_i ? 1'b0 : (err | (valid_i & (outstanding == '0)));

    if (clr_i) begin
      state_next = (outstanding_next != '0) ? DROP : IDLE;
    end else begin
      case (state)
        IDLE: if (level <= cfg_low_i) state_next = FILL;
        FILL: if (reserved_next == DEPTH_RES) state_next = IDLE;
        DROP: if (outstanding_next == '0) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      state       <= state_next;
      level       <= level_next;
      outstanding <= outstanding_next;
      err         <= err_next;
      if (clr_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        // Explicit wrap so non-power-of-two depths work.
        if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

endmodule

// File: tb/tb_udma_hyper_tx_prefetch.sv
// Directed bench for udma_hyper_tx_prefetch: default instance plus a 64/12/1 instance.
module tb_udma_hyper_tx_prefetch;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clr = 1'b0;
  logic        gnt = 1'b0;
  logic        valid = 1'b0;
  logic        ready = 1'b0;
  logic        sel = 1'b0;
  logic [63:0] din = '0;
  logic [4:0]  cfg = '0;

  logic        req1, rdy1, vld1, err1;
  logic [31:0] data1;
  logic [4:0]  lvl1;
  logic [2:0]  out1;
  logic        req2, rdy2, vld2, err2;
  logic [63:0] data2;
  logic [3:0]  lvl2;
  logic [0:0]  out2;

  logic        cur_req, cur_ready, cur_valid, cur_err;
  logic [63:0] cur_data;
  logic [4:0]  cur_level;
  logic [2:0]  cur_out;

  always #5 clk = ~clk;

  udma_hyper_tx_prefetch #(.DATA_WIDTH(32), .BUFFER_DEPTH(16), .MAX_OUTSTANDING(4)) dut1 (
    .sys_clk_i(clk), .rstn_i(rstn), .clr_i(clr & ~sel), .cfg_low_i(cfg),
    .req_o(req1), .gnt_i(gnt & ~sel), .valid_i(valid & ~sel), .data_i(din[31:0]),
    .ready_o(rdy1), .data_o(data1), .valid_o(vld1), .ready_i(ready & ~sel),
    .level_o(lvl1), .outstanding_o(out1), .err_o(err1)
  );

  udma_hyper_tx_prefetch #(.DATA_WIDTH(64), .BUFFER_DEPTH(12), .MAX_OUTSTANDING(1)) dut2 (
    .sys_clk_i(clk), .rstn_i(rstn), .clr_i(clr & sel), .cfg_low_i(cfg[3:0]),
    .req_o(req2), .gnt_i(gnt & sel), .valid_i(valid & sel), .data_i(din),
    .ready_o(rdy2), .data_o(data2), .valid_o(vld2), .ready_i(ready & sel),
    .level_o(lvl2), .outstanding_o(out2), .err_o(err2)
  );

  assign cur_req   = sel ? req2 : req1;
  assign cur_ready = sel ? rdy2 : rdy1;
  assign cur_valid = sel ? vld2 : vld1;
  assign cur_err   = sel ? err2 : err1;
  assign cur_data  = sel ? data2 : {32'b0, data1};
  assign cur_level = sel ? {1'b0, lvl2} : lvl1;
  assign cur_out   = sel ? {2'b0, out2} : out1;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          lat = 2;
  int          seq = 0;
  int          grants = 0;
  int          pops = 0;
  int          max_out = 0;
  int          ready_low = 0;
  int          discard = 0;
  bit          hold = 1'b0;
  bit          resp_beat = 1'b0;
  int          due_q[$];
  logic [63:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mkdata(input int s);
    return {32'(s) ^ 32'h5A5A_0000, 32'hA000_0000 + 32'(s)};
  endfunction

  // One clock: account for this edge's grant/pop/push, then drive the responder.
  task automatic step();
    logic g, p;
    g = cur_req & gnt;
    p = cur_valid & ready;
    if (!cur_ready) ready_low++;
    if (g) begin
      due_q.push_back(cyc + lat);
      grants++;
    end
    if (p && !clr) begin
      pops++;
      if (exp_q.size() == 0) check_eq("pop_underflow", 64'(exp_q.size()), 64'd1);
      else check_eq("pop_data", cur_data, exp_q.pop_front());
    end
    if (resp_beat && !clr) begin
      if (discard > 0) discard--;
      else exp_q.push_back(sel ? din : {32'b0, din[31:0]});
    end
    if (clr) exp_q.delete();
    @(posedge clk);
    #1;
    cyc++;
    if (!hold && due_q.size() > 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      valid     = 1'b1;
      din       = mkdata(seq);
      seq++;
      resp_beat = 1'b1;
    end else begin
      valid     = 1'b0;
      din       = '0;
      resp_beat = 1'b0;
    end
    #1;
    if (int'(cur_out) > max_out) max_out = int'(cur_out);
  endtask

  task automatic do_reset();
    rstn = 1'b0; clr = 1'b0; gnt = 1'b0; valid = 1'b0; ready = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    due_q.delete(); exp_q.delete();
    grants = 0; max_out = 0; ready_low = 0; discard = 0; hold = 1'b0; resp_beat = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lvl_before, seq_flush, bad, pops_start;

    // Reset state
    sel = 1'b0;
    cfg = 5'd4;
    do_reset();
    check_eq("rst_level", 64'(cur_level), 64'd0);
    check_eq("rst_out", 64'(cur_out), 64'd0);
    check_eq("rst_err", 64'(cur_err), 64'd0);
    check_eq("rst_req", 64'(cur_req), 64'd0);
    check_eq("rst_valid", 64'(cur_valid), 64'd0);
    check_eq("rst_data", cur_data, 64'd0);
    check_eq("rst_ready", 64'(cur_ready), 64'd1);

    // 1: fill from empty, credit-limited
    lat = 6; gnt = 1'b1; ready = 1'b0;
    for (int i = 0; i < 200 && !(cur_level == 5'd16 && cur_out == 3'd0); i++) step();
    check_eq("t1_level", 64'(cur_level), 64'd16);
    check_eq("t1_out", 64'(cur_out), 64'd0);
    check_eq("t1_grants", 64'(grants), 64'd16);
    check_eq("t1_max_out", 64'(max_out), 64'd4);
    check_eq("t1_req", 64'(cur_req), 64'd0);

    // 2: drain until low watermark, then refill to full
    lat = 2; ready = 1'b1;
    for (int i = 0; i < 40 && !cur_req; i++) step();
    check_eq("t2_req_level", 64'(cur_level), 64'd3);
    ready = 1'b0; grants = 0;
    for (int i = 0; i < 100 && !(cur_level == 5'd16 && cur_out == 3'd0); i++) step();
    check_eq("t2_grants", 64'(grants), 64'd13);
    check_eq("t2_level", 64'(cur_level), 64'd16);
    check_eq("t2_req", 64'(cur_req), 64'd0);

    // 3: steady push+pop at level 8
    cfg = 5'd15; gnt = 1'b0; ready = 1'b1;
    for (int i = 0; i < 40 && cur_level != 5'd8; i++) step();
    check_eq("t3_start_level", 64'(cur_level), 64'd8);
    ready = 1'b0; gnt = 1'b1;
    step(); step();
    ready = 1'b1; bad = 0; pops_start = pops;
    for (int i = 0; i < 100; i++) begin
      step();
      if (cur_level != 5'd8) bad++;
    end
    check_eq("t3_level_hold", 64'(bad), 64'd0);
    check_eq("t3_pops", 64'(pops - pops_start), 64'd100);
    gnt = 1'b0; ready = 1'b0;
    for (int i = 0; i < 20 && !(cur_out == 3'd0 && !valid); i++) step();
    check_eq("t3_drain_level", 64'(cur_level), 64'd10);

    // 4: flush with three requests in flight
    hold = 1'b1; gnt = 1'b1;
    repeat (3) step();
    gnt = 1'b0;
    check_eq("t4_out_before", 64'(cur_out), 64'd3);
    seq_flush = seq;
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("t4_level", 64'(cur_level), 64'd0);
    check_eq("t4_valid", 64'(cur_valid), 64'd0);
    check_eq("t4_out_after", 64'(cur_out), 64'd3);
    check_eq("t4_req_drop", 64'(cur_req), 64'd0);
    hold = 1'b0; discard = 3; gnt = 1'b1; grants = 0; bad = 0;
    for (int i = 0; i < 20 && cur_out != 3'd0; i++) begin
      step();
      if (cur_req) bad++;
    end
    check_eq("t4_out_done", 64'(cur_out), 64'd0);
    check_eq("t4_req_during_drop", 64'(bad), 64'd0);
    check_eq("t4_grants_during_drop", 64'(grants), 64'd0);
    check_eq("t4_level_drop", 64'(cur_level), 64'd0);
    check_eq("t4_err", 64'(cur_err), 64'd0);
    step();
    check_eq("t4_refill_req", 64'(cur_req), 64'd1);
    ready = 1'b1;
    for (int i = 0; i < 20 && !cur_valid; i++) step();
    check_eq("t4_first_data", cur_data, {32'b0, mkdata(seq_flush + 3) & 64'h0000_0000_FFFF_FFFF});
    repeat (20) step();

    // 5: orphan beat sets sticky error
    gnt = 1'b0; ready = 1'b0;
    for (int i = 0; i < 40 && !(due_q.size() == 0 && cur_out == 3'd0 && !valid); i++) step();
    lvl_before = int'(cur_level);
    valid = 1'b1; din = 64'hDEAD_BEEF;
    #1;
    step();
    check_eq("t5_err_set", 64'(cur_err), 64'd1);
    check_eq("t5_level", 64'(cur_level), 64'(lvl_before));
    check_eq("t5_out", 64'(cur_out), 64'd0);
    step();
    check_eq("t5_err_sticky", 64'(cur_err), 64'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("t5_err_clr", 64'(cur_err), 64'd0);
    check_eq("t5_level_clr", 64'(cur_level), 64'd0);
    check_eq("ready_never_low", 64'(ready_low), 64'd0);

    // 6: 64-bit, depth 12, single outstanding
    sel = 1'b1; cfg = 5'd4; lat = 2;
    do_reset();
    check_eq("t6_rst_level", 64'(cur_level), 64'd0);
    check_eq("t6_rst_valid", 64'(cur_valid), 64'd0);
    gnt = 1'b1; ready = 1'b0;
    for (int i = 0; i < 100 && !(cur_level == 5'd12 && cur_out == 3'd0); i++) step();
    check_eq("t6_level", 64'(cur_level), 64'd12);
    check_eq("t6_grants", 64'(grants), 64'd12);
    check_eq("t6_max_out", 64'(max_out), 64'd1);
    check_eq("t6_req", 64'(cur_req), 64'd0);
    ready = 1'b1; pops_start = pops;
    repeat (60) step();
    check_eq("t6_wrap_pops", 64'((pops - pops_start) > 24), 64'd1);
    check_eq("t6_max_out_run", 64'(max_out), 64'd1);
    check_eq("t6_err", 64'(cur_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
